// File: rtl/svfloat_unpacker_pipe.sv
// svfloat_unpacker_pipe: multi-lane float unpacker with class flags, DAZ,
// subnormal renormalization and 1- or 2-stage valid/ready pipeline.
module svfloat_unpacker_pipe #(
  parameter int EW = 8,
  parameter int MW = 23,
  parameter int LANES = 1,
  parameter int STAGES = 2,
  localparam int FW = 1 + EW + MW,
  localparam int BIAS = (1 << (EW - 1)) - 1,
  localparam int MAG = (MW > 2) ? BIAS + MW - 1 : BIAS + 1,
  localparam int TW = $clog2(MAG + 1) + 1,
  localparam int PW = (MW > 1) ? $clog2(MW) : 1,
  localparam int SW = PW + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES-1:0][FW-1:0] in_data,
  input  logic                     in_daz,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES-1:0]         out_sign,
  output logic [LANES-1:0][TW-1:0] out_exp,
  output logic [LANES-1:0][MW:0]   out_man,
  output logic [LANES-1:0]         out_zero,
  output logic [LANES-1:0]         out_sub,
  output logic [LANES-1:0]         out_inf,
  output logic [LANES-1:0]         out_qnan,
  output logic [LANES-1:0]         out_snan
);

  typedef struct packed {
    logic zero;
    logic sub;
    logic inf;
    logic qnan;
    logic snan;
  } cls_t;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] e;
    logic [MW-1:0] m;
    cls_t          c;
    logic [PW-1:0] p;
  } fld_t;

  typedef struct packed {
    logic          sign;
    logic [TW-1:0] exp;
    logic [MW:0]   man;
    cls_t          c;
  } res_t;

  function automatic fld_t split(logic [FW-1:0] x, logic daz);
    fld_t f;
    logic e_zero;
    logic e_max;
    logic m_zero;
    f.sign = x[FW-1];
    f.e = x[FW-2:MW];
    f.m = x[MW-1:0];
    e_zero = (f.e == '0);
    e_max = (f.e == '1);
    m_zero = (f.m == '0);
    f.c.zero = e_zero && (m_zero || daz);
    f.c.sub = e_zero && !m_zero && !daz;
    f.c.inf = e_max && m_zero;
    f.c.qnan = e_max && f.m[MW-1];
    f.c.snan = e_max && !f.m[MW-1] && !m_zero;
    f.p = '0;
    for (int i = 0; i < MW; i++)
      if (f.m[i]) f.p = PW'(i);
    return f;
  endfunction

  function automatic res_t finish(fld_t f);
    res_t r;
    r.sign = f.sign;
    r.c = f.c;
    r.exp = TW'(f.e) - TW'(BIAS);
    r.man = {1'b1, f.m};
    if (f.c.zero) begin
      r.exp = TW'(1 - BIAS - MW);
      r.man = '0;
    end else if (f.c.sub) begin
      r.exp = TW'(1 - BIAS - MW) + TW'(f.p);
      r.man = {1'b0, f.m} << (SW'(MW) - SW'(f.p));
    end
    return r;
  endfunction

  res_t [LANES-1:0] res_d;
  res_t [LANES-1:0] res_q;
  logic             v_q;
  logic             adv;
  logic             nxt_v;

  assign adv = !v_q || out_ready;

  if (STAGES == 2) begin : g_two
    fld_t [LANES-1:0] f_q;
    logic             v1_q;

    assign in_ready = !flush && (!v1_q || adv);
    assign nxt_v = v1_q;

    // stage 1: split fields, classify, find leading one
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v1_q <= 1'b0;
        f_q <= '0;
      end else begin
        if (flush) v1_q <= 1'b0;
        else if (!v1_q || adv) v1_q <= in_valid;
        if (in_valid && in_ready)
          for (int i = 0; i < LANES; i++)
            f_q[i] <= split(in_data[i], in_daz);
      end
    end

    // stage 2 input: normalize from registered fields
    always_comb begin
      for (int i = 0; i < LANES; i++)
        res_d[i] = finish(f_q[i]);
    end
  end else if (STAGES == 1) begin : g_one
    assign in_ready = !flush && adv;
    assign nxt_v = in_valid && in_ready;

    // whole unpack in front of the single register
    always_comb begin
      for (int i = 0; i < LANES; i++)
        res_d[i] = finish(split(in_data[i], in_daz));
    end
  end else begin : g_bad
    $error("svfloat_unpacker_pipe: STAGES must be 1 or 2");
  end

  // output stage: holds result until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      res_q <= '0;
    end else begin
      if (flush) v_q <= 1'b0;
      else if (adv) v_q <= nxt_v;
      if (adv && nxt_v) res_q <= res_d;
    end
  end

  assign out_valid = v_q;

  // fan registered lanes out to flat ports
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      out_sign[i] = res_q[i].sign;
      out_exp[i] = res_q[i].exp;
      out_man[i] = res_q[i].man;
      out_zero[i] = res_q[i].c.zero;
      out_sub[i] = res_q[i].c.sub;
      out_inf[i] = res_q[i].c.inf;
      out_qnan[i] = res_q[i].c.qnan;
      out_snan[i] = res_q[i].c.snan;
    end
  end

endmodule

// File: tb/tb_svfloat_unpacker_pipe.sv
// tb_svfloat_unpacker_pipe: directed and random checks of the unpacker
// in 1-lane/2-stage and 2-lane/1-stage configurations.
module tb_svfloat_unpacker_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            a_flush, a_iv, a_ir, a_daz, a_ov, a_or;
  logic [0:0][31:0] a_data;
  logic [0:0]      a_sign, a_zero, a_sub, a_inf, a_qnan, a_snan;
  logic [0:0][8:0] a_exp;
  logic [0:0][23:0] a_man;

  logic            b_flush, b_iv, b_ir, b_daz, b_ov, b_or;
  logic [1:0][31:0] b_data;
  logic [1:0]      b_sign, b_zero, b_sub, b_inf, b_qnan, b_snan;
  logic [1:0][8:0] b_exp;
  logic [1:0][23:0] b_man;

  svfloat_unpacker_pipe #(.LANES(1), .STAGES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_data),
    .in_daz(a_daz), .out_valid(a_ov), .out_ready(a_or),
    .out_sign(a_sign), .out_exp(a_exp), .out_man(a_man),
    .out_zero(a_zero), .out_sub(a_sub), .out_inf(a_inf),
    .out_qnan(a_qnan), .out_snan(a_snan)
  );

  svfloat_unpacker_pipe #(.LANES(2), .STAGES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_data),
    .in_daz(b_daz), .out_valid(b_ov), .out_ready(b_or),
    .out_sign(b_sign), .out_exp(b_exp), .out_man(b_man),
    .out_zero(b_zero), .out_sub(b_sub), .out_inf(b_inf),
    .out_qnan(b_qnan), .out_snan(b_snan)
  );

  // {sign, exp[8:0], man[23:0], zero, sub, inf, qnan, snan}
  typedef logic [38:0] ref_t;

  int     checks = 0;
  int     errors = 0;
  int     consumed = 0;
  ref_t   q[$];
  string  tag = "";
  logic   last_acc;
  logic   use_dir = 1'b0;
  ref_t   dir_exp;

  function automatic ref_t model(logic [31:0] x, logic daz);
    int e;
    int ex;
    longint mm;
    logic [4:0] fl;
    e = int'(x[30:23]);
    mm = longint'(x[22:0]);
    fl = 5'b0;
    if (e == 255) begin
      ex = 128;
      if (mm == 0) fl = 5'b00100;
      else if (x[22]) fl = 5'b00010;
      else fl = 5'b00001;
      mm = mm + 8388608;
    end else if (e == 0 && (mm == 0 || daz)) begin
      ex = -149;
      mm = 0;
      fl = 5'b10000;
    end else if (e == 0) begin
      ex = -126;
      fl = 5'b01000;
      while (mm < 8388608) begin
        mm = mm * 2;
        ex = ex - 1;
      end
    end else begin
      ex = e - 127;
      mm = mm + 8388608;
    end
    return {x[31], 9'(ex), 24'(mm), fl};
  endfunction

  function automatic ref_t obs_a();
    return {a_sign[0], a_exp[0], a_man[0], a_zero[0], a_sub[0],
            a_inf[0], a_qnan[0], a_snan[0]};
  endfunction

  function automatic ref_t obs_b(int i);
    return {b_sign[i], b_exp[i], b_man[i], b_zero[i], b_sub[i],
            b_inf[i], b_qnan[i], b_snan[i]};
  endfunction

  function automatic logic [31:0] rand_float();
    logic [31:0] x;
    logic [22:0] m;
    int sel;
    sel = $urandom_range(0, 3);
    m = 23'($urandom() >> $urandom_range(0, 31));
    x[31] = 1'($urandom_range(0, 1));
    x[22:0] = m;
    if (sel == 0) x[30:23] = 8'h00;
    else if (sel == 1) x[30:23] = 8'hFF;
    else x[30:23] = 8'($urandom());
    return x;
  endfunction

  task automatic chk(string t, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs, expv);
    end
  endtask

  task automatic tick();
    logic cons;
    logic fl;
    @(negedge clk);
    last_acc = a_iv && a_ir;
    cons = a_ov && a_or;
    fl = a_flush;
    @(posedge clk);
    if (last_acc) q.push_back(use_dir ? dir_exp : model(a_data[0], a_daz));
    if (cons && q.size() > 0) begin
      void'(q.pop_front());
      consumed++;
    end
    if (fl) q.delete();
    #1;
    if (a_ov) begin
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL %s output_with_nothing_pending observed=1 expected=0", tag);
      end
      if (q.size() > 0) chk(tag, 64'(obs_a()), 64'(q[0]));
    end
  endtask

  logic [31:0] dir_in [10];
  logic        dir_daz [10];
  ref_t        dir_ref [10];
  logic [31:0] bpv [5];
  int          idx;

  initial begin
    dir_in = '{32'h3F800000, 32'hC0490FDB, 32'h00000001, 32'h00400000,
               32'h00000001, 32'h00400000, 32'h7F800000, 32'h7FC00000,
               32'h7F800001, 32'h80000000};
    dir_daz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    dir_ref = '{{1'b0, 9'h000, 24'h800000, 5'b00000},
                {1'b1, 9'h001, 24'hC90FDB, 5'b00000},
                {1'b0, 9'h16B, 24'h800000, 5'b01000},
                {1'b0, 9'h181, 24'h800000, 5'b01000},
                {1'b0, 9'h16B, 24'h000000, 5'b10000},
                {1'b0, 9'h16B, 24'h000000, 5'b10000},
                {1'b0, 9'h080, 24'h800000, 5'b00100},
                {1'b0, 9'h080, 24'hC00000, 5'b00010},
                {1'b0, 9'h080, 24'h800001, 5'b00001},
                {1'b1, 9'h16B, 24'h000000, 5'b10000}};

    a_flush = 0; a_iv = 0; a_daz = 0; a_or = 1; a_data = '0;
    b_flush = 0; b_iv = 0; b_daz = 0; b_or = 1; b_data = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_a_valid", 64'(a_ov), 64'(0));
    chk("reset_a_data", 64'(obs_a()), 64'(0));
    chk("reset_a_ready", 64'(a_ir), 64'(1));
    chk("reset_b_valid", 64'(b_ov), 64'(0));
    chk("reset_b_lane0", 64'(obs_b(0)), 64'(0));
    chk("reset_b_lane1", 64'(obs_b(1)), 64'(0));
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 64'(a_ir), 64'(1));

    tag = "latency";
    use_dir = 1'b1;
    a_iv = 1; a_data[0] = dir_in[0]; dir_exp = dir_ref[0];
    tick();
    a_iv = 0;
    chk("lat_not_yet", 64'(a_ov), 64'(0));
    tick();
    chk("lat_valid", 64'(a_ov), 64'(1));
    tick();

    tag = "directed";
    for (int i = 0; i < 10; i++) begin
      a_iv = 1; a_data[0] = dir_in[i]; a_daz = dir_daz[i];
      dir_exp = dir_ref[i];
      tick();
    end
    a_iv = 0; a_daz = 0;
    repeat (3) tick();
    chk("directed_drained", 64'(q.size()), 64'(0));
    use_dir = 1'b0;

    tag = "lanes";
    b_iv = 1; b_data[0] = 32'h00000003; b_data[1] = 32'h7F800000;
    @(negedge clk);
    chk("lanes_ready", 64'(b_ir), 64'(1));
    @(posedge clk);
    #1;
    b_iv = 0;
    chk("lanes_latency1", 64'(b_ov), 64'(1));
    chk("lanes_l0_sub", 64'(obs_b(0)), 64'({1'b0, 9'h16C, 24'hC00000, 5'b01000}));
    chk("lanes_l1_inf", 64'(obs_b(1)), 64'({1'b0, 9'h080, 24'h800000, 5'b00100}));
    @(posedge clk);
    #1;
    chk("lanes_idle", 64'(b_ov), 64'(0));
    for (int k = 0; k < 20; k++) begin
      b_iv = 1; b_daz = 1'($urandom_range(0, 1));
      b_data[0] = rand_float(); b_data[1] = rand_float();
      @(posedge clk);
      #1;
      chk("lanes_rand_valid", 64'(b_ov), 64'(1));
      chk("lanes_rand_l0", 64'(obs_b(0)), 64'(model(b_data[0], b_daz)));
      chk("lanes_rand_l1", 64'(obs_b(1)), 64'(model(b_data[1], b_daz)));
    end
    b_iv = 0;

    tag = "backpressure";
    for (int i = 0; i < 5; i++) bpv[i] = rand_float();
    idx = 0;
    consumed = 0;
    for (int c = 0; c < 14; c++) begin
      a_or = !(c >= 2 && c < 6);
      a_iv = (idx < 5);
      a_data[0] = bpv[idx % 5];
      if (c >= 2 && c < 6) begin
        #1;
        chk("bp_in_ready_low", 64'(a_ir), 64'(0));
      end
      tick();
      if (last_acc) idx++;
    end
    a_iv = 0; a_or = 1;
    chk("bp_consumed", 64'(consumed), 64'(5));
    chk("bp_accepted", 64'(idx), 64'(5));
    chk("bp_drained", 64'(q.size()), 64'(0));

    tag = "flush";
    a_or = 0; a_iv = 1;
    a_data[0] = rand_float();
    tick();
    a_data[0] = rand_float();
    tick();
    chk("flush_full", 64'(a_ov), 64'(1));
    a_flush = 1; a_data[0] = rand_float();
    #1;
    chk("flush_in_ready", 64'(a_ir), 64'(0));
    tick();
    a_flush = 0; a_iv = 0;
    chk("flush_cleared", 64'(a_ov), 64'(0));
    tick();
    a_or = 1;
    chk("flush_empty1", 64'(a_ov), 64'(0));
    tick();
    chk("flush_empty2", 64'(a_ov), 64'(0));

    tag = "reset_mid";
    a_iv = 1; a_data[0] = rand_float();
    tick();
    a_data[0] = rand_float();
    tick();
    chk("rst_pre_valid", 64'(a_ov), 64'(1));
    rst_n = 1'b0;
    #1;
    a_iv = 0;
    chk("rst_valid", 64'(a_ov), 64'(0));
    chk("rst_data", 64'(obs_a()), 64'(0));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("rst_no_emit", 64'(a_ov), 64'(0));

    tag = "random";
    for (int c = 0; c < 400; c++) begin
      a_iv = ($urandom_range(0, 3) != 0);
      a_or = ($urandom_range(0, 3) != 0);
      a_daz = 1'($urandom_range(0, 1));
      a_flush = ($urandom_range(0, 49) == 0);
      a_data[0] = rand_float();
      tick();
    end
    a_iv = 0; a_or = 1; a_flush = 0;
    repeat (4) tick();
    chk("rand_drained", 64'(q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
